// File: rtl/moving_sum_pkg.sv
// Shared sizing helpers for the boxcar filter datapath.
// Both moving_sum and any delay_line instance feeding it derive their
// window length and accumulator width from these so the two stay aligned.
package moving_sum_pkg;

    localparam int N_DEF     = 4;   // default sample width
    localparam int LOG2W_DEF = 2;   // default log2 window length

    // Window length for a given log2 size.
    function automatic int w_of(input int l);
        return 1 << l;
    endfunction

    // Accumulator width: W samples of N bits never exceed N+LOG2W bits.
    function automatic int acc_w(input int n, input int l);
        return n + l;
    endfunction

endpackage

// File: rtl/moving_sum.sv
// moving_sum: windowed moving sum / average over the last W = 2**LOG2W samples.
// Sits directly after a delay_line of depth W on the same clk/ce. Each ce
// cycle adds the new sample and subtracts the one leaving the window.
//
// Ports:
//   clk    in   1          rising-edge clock
//   rst_n  in   1          asynchronous active-low reset
//   ce     in   1          sample strobe (shared with delay_line)
//   clr    in   1          synchronous clear of accumulator and fill count
//   idata  in   N          newest sample
//   ddata  in   N          delay_line output: idata of W ce-cycles earlier
//   sum    out  N+LOG2W    registered sum of the last W samples
//   avg    out  N          registered sum >> LOG2W (truncating)
//   valid  out  1          high once W samples have been accumulated
module moving_sum
    import moving_sum_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int LOG2W = LOG2W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic                  clr,
    input  logic [N-1:0]          idata,
    input  logic [N-1:0]          ddata,
    output logic [N+LOG2W-1:0]    sum,
    output logic [N-1:0]          avg,
    output logic                  valid
);

    localparam int               W     = w_of(LOG2W);
    localparam int               AW    = acc_w(N, LOG2W);
    localparam logic [LOG2W:0]   W_CNT = (LOG2W + 1)'(W);

    logic [AW-1:0]  acc_q, acc_d;
    logic [LOG2W:0] cnt_q, cnt_d;
    logic           full;
    logic [AW-1:0]  add_ext, sub_ext;

    assign full    = (cnt_q == W_CNT);
    assign add_ext = {{LOG2W{1'b0}}, idata};
    // Until the window is full the delay line holds reset/stale data that was
    // never added, so it must not be subtracted.
    assign sub_ext = full ? {{LOG2W{1'b0}}, ddata} : '0;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clr) begin
            // A sample presented with clr is dropped; the delay line still
            // shifts it in, but the fill count restarts so it is masked later.
            acc_d = '0;
            cnt_d = '0;
        end else if (ce) begin
            acc_d = acc_q + add_ext - sub_ext;
            cnt_d = full ? W_CNT : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    // Outputs come straight from state registers: no input-to-output path.
    assign sum   = acc_q;
    assign avg   = acc_q[AW-1:LOG2W];
    assign valid = full;

endmodule

// File: tb/tb_moving_sum.sv
`timescale 1ns/100ps
module tb_moving_sum;

    localparam int N     = 4;
    localparam int LOG2W = 2;
    localparam int W     = 1 << LOG2W;

    logic             clk = 1'b0;
    logic             rst_n, ce, clr;
    logic [N-1:0]     idata, ddata;
    logic [N+LOG2W-1:0] sum;
    logic [N-1:0]     avg;
    logic             valid;

    always #1 clk = ~clk;

    moving_sum #(.N(N), .LOG2W(LOG2W)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .clr(clr),
        .idata(idata), .ddata(ddata),
        .sum(sum), .avg(avg), .valid(valid)
    );

    // Behavioural delay line feeding ddata; deliberately not cleared on reset
    // so stale contents exercise the pre-fill masking.
    logic [N-1:0] dl [W];
    assign ddata = dl[W-1];

    typedef struct { int s; int a; bit v; } exp_t;
    exp_t   sb[$];
    int     win[$];
    int     tests = 0, fails = 0;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int t = 0;
        foreach (win[i]) t += win[i];
        e.s = t;
        e.a = t / W;
        e.v = (win.size() == W);
        return e;
    endfunction

    // One clocked step: drive at negedge, update the reference just after the edge.
    task automatic step(input bit c, input bit cl, input int d);
        @(negedge clk);
        ce = c; clr = cl; idata = N'(d);
        @(posedge clk);
        #0.5;
        if (cl) win.delete();
        else if (c) begin
            win.push_back(d);
            if (win.size() > W) void'(win.pop_front());
        end
        if (c) begin
            for (int i = W-1; i > 0; i--) dl[i] = dl[i-1];
            dl[0] = N'(d);
        end
        sb.push_back(model_out());
    endtask

    // Monitor: outputs are valid every cycle; compare away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sum",   int'(sum),   e.s);
                chk("avg",   int'(avg),   e.a);
                chk("valid", int'(valid), int'(e.v));
            end
        end
    end

    initial begin
        for (int i = 0; i < W; i++) dl[i] = 4'hA;
        rst_n = 1'b0; ce = 1'b0; clr = 1'b0; idata = '0;

        // 1. reset held 3 clocks, then idle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_sum", int'(sum), 0);
            chk("rst_valid", int'(valid), 0);
        end
        @(negedge clk); rst_n = 1'b1;
        step(0, 0, 7); step(0, 0, 3);

        // 2. fill then one slide
        for (int i = 1; i <= 5; i++) step(1, 0, i);
        // 3. gaps: ce 1,0,0,1
        step(1, 0, 6); step(0, 0, 9); step(0, 0, 9); step(1, 0, 7);
        // 4. max value
        for (int i = 0; i < 8; i++) step(1, 0, 15);
        // 5. clr with ce mid-stream, then refill
        step(1, 0, 3);
        step(1, 1, 9);
        for (int i = 0; i < 4; i++) step(1, 0, 1);
        step(1, 0, 2);

        // 6. async reset mid-fill
        step(1, 1, 0);
        step(1, 0, 5); step(1, 0, 5);
        @(negedge clk); ce = 1'b0; clr = 1'b0;
        #0.5 rst_n = 1'b0;
        #0.1;
        chk("arst_sum", int'(sum), 0);
        chk("arst_avg", int'(avg), 0);
        chk("arst_valid", int'(valid), 0);
        win.delete();
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1, 0, 2);
        @(negedge clk); #0.1;
        chk("refill_sum", int'(sum), 8);
        chk("refill_valid", int'(valid), 1);

        // random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(99) < 70, $urandom_range(99) < 5,
                 int'($urandom_range(15)));

        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
        #0.1;
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
